// File: rtl/fifo_pkg.sv
// Shared types and sizing for the convolver FIFO controller.
// Sizing comes from `ADDR_FIFO / `DEP_FIFO (defaults 3 / 6).
`ifndef ADDR_FIFO
`define ADDR_FIFO 3
`endif
`ifndef DEP_FIFO
`define DEP_FIFO 6
`endif

package fifo_pkg;
  localparam int ADDR_W = `ADDR_FIFO;
  localparam int DEPTH  = `DEP_FIFO;
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] fifo_addr_t;
  typedef logic [CNT_W-1:0]  fifo_cnt_t;

  typedef enum logic {
    PRESENT_EMPTY = 1'b0,
    PRESENT_VALID = 1'b1
  } fwft_state_t;

  localparam fifo_cnt_t  DEPTH_C = fifo_cnt_t'(DEPTH);
  localparam fifo_addr_t LAST    = fifo_addr_t'(DEPTH - 1);
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances on inc, wraps DEPTH-1 -> 0.
// Used for both the write and read side of fifo_ctrl.
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output fifo_addr_t ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Control stage for the convolver's dual-port FIFO array.
// Define FIFO_CTRL_FWFT_EN for first-word-fall-through.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       wr_en,
  output logic       full,
  output logic       almost_full,
  input  logic       rd_en,
  output logic       empty,
  output logic       rd_valid,
  output fifo_cnt_t  count,
  output logic       ovf,
  output logic       udf,
  output logic       mem_we,
  output fifo_addr_t mem_waddr,
  output logic       mem_re,
  output fifo_addr_t mem_raddr
);

  fifo_addr_t wptr;
  fifo_addr_t rptr;
  fifo_cnt_t  cnt_q;
  fifo_cnt_t  cnt_d;
  logic       full_q;
  logic       af_q;
  logic       ovf_q;
  logic       udf_q;
  logic       push_ok;
  logic       pop_ok;
  logic       rd_inc;
  logic       rej_rd;

  assign push_ok   = wr_en & ~full_q & ~clr;
  assign mem_we    = push_ok;
  assign mem_waddr = wptr;
  assign mem_raddr = rptr;

`ifdef FIFO_CTRL_FWFT_EN
  fwft_state_t st_q;
  fwft_state_t st_d;
  fifo_cnt_t   scnt_q;
  fifo_cnt_t   scnt_d;
  logic        pf;

  // scnt counts words still in the array, not yet prefetched
  always_comb begin
    st_d = st_q;
    pf   = 1'b0;
    if (clr) begin
      st_d = PRESENT_EMPTY;
    end else begin
      unique case (st_q)
        PRESENT_EMPTY: begin
          if (scnt_q != '0) begin
            pf   = 1'b1;
            st_d = PRESENT_VALID;
          end
        end
        PRESENT_VALID: begin
          if (rd_en) begin
            pf   = (scnt_q != '0);
            st_d = pf ? PRESENT_VALID
                      : PRESENT_EMPTY;
          end
        end
        default: st_d = PRESENT_EMPTY;
      endcase
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (clr) begin
      scnt_d = '0;
    end else begin
      scnt_d = scnt_q
             + fifo_cnt_t'(push_ok)
             - fifo_cnt_t'(pf);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= PRESENT_EMPTY;
      scnt_q <= '0;
    end else begin
      st_q   <= st_d;
      scnt_q <= scnt_d;
    end
  end

  assign rd_valid = (st_q == PRESENT_VALID);
  assign empty    = ~rd_valid;
  assign pop_ok   = rd_en & rd_valid & ~clr;
  assign rej_rd   = rd_en & ~rd_valid;
  assign mem_re   = pf;
  assign rd_inc   = pf;
`else
  logic empty_q;
  logic rv_q;

  assign pop_ok   = rd_en & ~empty_q & ~clr;
  assign rej_rd   = rd_en & empty_q;
  assign mem_re   = pop_ok;
  assign rd_inc   = pop_ok;
  assign rd_valid = rv_q;
  assign empty    = empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_q <= 1'b1;
      rv_q    <= 1'b0;
    end else begin
      empty_q <= (cnt_d == '0);
      rv_q    <= pop_ok;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (push_ok & ~pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok & ~push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_C);
      af_q   <= (cnt_d >= fifo_cnt_t'(AF_LVL));
      if (clr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (wr_en & full_q) ovf_q <= 1'b1;
        if (rej_rd)         udf_q <= 1'b1;
      end
    end
  end

  fifo_ptr u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (push_ok),
    .ptr   (wptr)
  );

  fifo_ptr u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (rd_inc),
    .ptr   (rptr)
  );

  assign count       = cnt_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue reference model plus a behavioural
// dual-port array with 1-cycle registered read.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_en;
  logic       rd_en;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic       rd_valid;
  fifo_cnt_t  count;
  logic       ovf;
  logic       udf;
  logic       mem_we;
  fifo_addr_t mem_waddr;
  logic       mem_re;
  fifo_addr_t mem_raddr;

  logic [15:0] wdata;
  logic [15:0] dout;
  logic [15:0] arr [2**ADDR_W];

  int vec  = 0;
  int errs = 0;

  // reference model state
  logic [15:0] q [$];
  int          pushes;
  int          pops;
  bit          m_ovf;
  bit          m_udf;
  bit          m_rv;
  logic [15:0] m_dout;
  logic [15:0] last_w;
  bit          e_push;
  bit          e_pop;
  int          e_waddr;
  int          e_raddr;

  // sampled combinational outputs just before the edge
  logic       o_we;
  logic       o_re;
  fifo_addr_t o_waddr;
  fifo_addr_t o_raddr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) arr[mem_waddr] <= wdata;
    if (mem_re) dout <= arr[mem_raddr];
  end

  fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .empty       (empty),
    .rd_valid    (rd_valid),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_re      (mem_re),
    .mem_raddr   (mem_raddr)
  );

  task automatic mreset();
    q.delete();
    pushes = 0;
    pops   = 0;
    m_ovf  = 0;
    m_udf  = 0;
    m_rv   = 0;
  endtask

  // one clock: drive, sample comb outputs, edge, advance model
  task automatic cyc(input bit wr, input bit rd, input bit c);
    wr_en   = wr;
    rd_en   = rd;
    clr     = c;
    wdata   = 16'($urandom);
    e_push  = wr && !c && (q.size() < DEPTH);
    e_pop   = rd && !c && (q.size() > 0);
    e_waddr = pushes % DEPTH;
    e_raddr = pops % DEPTH;
    #1;
    o_we    = mem_we;
    o_re    = mem_re;
    o_waddr = mem_waddr;
    o_raddr = mem_raddr;
    @(posedge clk);
    if (c) begin
      mreset();
    end else begin
      if (wr && !e_push) m_ovf = 1;
      if (rd && !e_pop)  m_udf = 1;
      m_rv = e_pop;
      if (e_pop) begin
        m_dout = q.pop_front();
        pops++;
      end
      if (e_push) begin
        q.push_back(wdata);
        last_w = wdata;
        pushes++;
      end
    end
    #1;
    wr_en = 0;
    rd_en = 0;
    clr   = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clr   = 0;
    wr_en = 0;
    rd_en = 0;
    wdata = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    vec++; if (count !== '0) begin errs++; $display("FAIL rst_count got %0d want 0", count); end
    vec++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %b want 1", empty); end
    vec++; if (full !== 1'b0) begin errs++; $display("FAIL rst_full got %b want 0", full); end
    vec++; if (almost_full !== 1'b0) begin errs++; $display("FAIL rst_af got %b want 0", almost_full); end
    vec++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL rst_rv got %b want 0", rd_valid); end
    vec++; if ({ovf, udf} !== 2'b00) begin errs++; $display("FAIL rst_flags got %b want 00", {ovf, udf}); end
    rst_n = 1;
  endtask

`ifndef FIFO_CTRL_FWFT_EN
  task automatic test_underflow();
    cyc(0, 1, 0);
    vec++; if (o_re !== 1'b0) begin errs++; $display("FAIL udf_re got %b want 0", o_re); end
    vec++; if (udf !== 1'b1) begin errs++; $display("FAIL udf_flag got %b want 1", udf); end
    vec++; if (count !== '0) begin errs++; $display("FAIL udf_count got %0d want 0", count); end
    cyc(0, 0, 0);
    vec++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL udf_rv got %b want 0", rd_valid); end
  endtask

  task automatic test_full_ovf();
    cyc(0, 0, 1);
    vec++; if (udf !== 1'b0) begin errs++; $display("FAIL clr_udf got %b want 0", udf); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0);
      vec++; if (o_we !== 1'b1 || o_waddr !== fifo_addr_t'(i)) begin errs++; $display("FAIL fill_we got %b/%0d want 1/%0d", o_we, o_waddr, i); end
      vec++; if (full !== (i == DEPTH - 1)) begin errs++; $display("FAIL fill_full i=%0d got %b", i, full); end
      vec++; if (almost_full !== (i + 1 >= DEPTH - 2)) begin errs++; $display("FAIL fill_af i=%0d got %b", i, almost_full); end
    end
    cyc(1, 0, 0);
    vec++; if (o_we !== 1'b0) begin errs++; $display("FAIL ovf_we got %b want 0", o_we); end
    vec++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", ovf); end
    vec++; if (count !== fifo_cnt_t'(DEPTH)) begin errs++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
  endtask

  task automatic test_full_both();
    cyc(1, 1, 0);
    vec++; if (o_we !== 1'b0 || o_re !== 1'b1) begin errs++; $display("FAIL fb_we_re got %b%b want 01", o_we, o_re); end
    vec++; if (o_raddr !== '0) begin errs++; $display("FAIL fb_raddr got %0d want 0", o_raddr); end
    vec++; if (count !== fifo_cnt_t'(DEPTH - 1)) begin errs++; $display("FAIL fb_count got %0d want %0d", count, DEPTH - 1); end
    vec++; if (rd_valid !== 1'b1 || dout !== m_dout) begin errs++; $display("FAIL fb_data got %b/%h want 1/%h", rd_valid, dout, m_dout); end
  endtask

  task automatic test_clr();
    cyc(1, 1, 1);
    vec++; if (o_we !== 1'b0 || o_re !== 1'b0) begin errs++; $display("FAIL clr_we_re got %b%b want 00", o_we, o_re); end
    vec++; if (count !== '0 || empty !== 1'b1) begin errs++; $display("FAIL clr_cnt got %0d/%b want 0/1", count, empty); end
    vec++; if ({ovf, udf, rd_valid} !== 3'b000) begin errs++; $display("FAIL clr_flags got %b want 000", {ovf, udf, rd_valid}); end
  endtask

  task automatic test_empty_both();
    cyc(1, 1, 0);
    vec++; if (o_we !== 1'b1 || o_re !== 1'b0) begin errs++; $display("FAIL eb_we_re got %b%b want 10", o_we, o_re); end
    vec++; if (count !== 1 || udf !== 1'b1) begin errs++; $display("FAIL eb_cnt got %0d/%b want 1/1", count, udf); end
  endtask

  task automatic test_latency();
    logic [15:0] a;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    a = last_w;
    vec++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL lat_rv0 got %b want 0", rd_valid); end
    cyc(0, 1, 0);
    vec++; if (o_re !== 1'b1 || o_raddr !== '0) begin errs++; $display("FAIL lat_raddr got %b/%0d want 1/0", o_re, o_raddr); end
    vec++; if (rd_valid !== 1'b1 || dout !== a) begin errs++; $display("FAIL lat_data got %b/%h want 1/%h", rd_valid, dout, a); end
    cyc(0, 0, 0);
    vec++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL lat_rv2 got %b want 0", rd_valid); end
  endtask

  task automatic test_interleave();
    logic [15:0] d;
    cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0);
      d = last_w;
      vec++; if (o_waddr !== fifo_addr_t'(i % DEPTH)) begin errs++; $display("FAIL il_waddr i=%0d got %0d want %0d", i, o_waddr, i % DEPTH); end
      cyc(0, 1, 0);
      vec++; if (o_raddr !== fifo_addr_t'(i % DEPTH)) begin errs++; $display("FAIL il_raddr i=%0d got %0d want %0d", i, o_raddr, i % DEPTH); end
      vec++; if (dout !== d) begin errs++; $display("FAIL il_data i=%0d got %h want %h", i, dout, d); end
    end
  endtask

  task automatic test_back_to_back();
    bit wr;
    bit rd;
    bit c;
    cyc(0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 99) == 0);
      cyc(wr, rd, c);
      vec++; if (o_we !== e_push || o_re !== e_pop) begin errs++; $display("FAIL rnd_we_re n=%0d got %b%b want %b%b", n, o_we, o_re, e_push, e_pop); end
      if (e_push) begin
        vec++; if (o_waddr !== fifo_addr_t'(e_waddr)) begin errs++; $display("FAIL rnd_waddr n=%0d got %0d want %0d", n, o_waddr, e_waddr); end
      end
      if (e_pop) begin
        vec++; if (o_raddr !== fifo_addr_t'(e_raddr)) begin errs++; $display("FAIL rnd_raddr n=%0d got %0d want %0d", n, o_raddr, e_raddr); end
      end
      vec++; if (count !== fifo_cnt_t'(q.size())) begin errs++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, q.size()); end
      vec++; if ({full, almost_full, empty} !== {q.size() == DEPTH, q.size() >= DEPTH - 2, q.size() == 0}) begin errs++; $display("FAIL rnd_flags n=%0d got %b", n, {full, almost_full, empty}); end
      vec++; if ({ovf, udf, rd_valid} !== {m_ovf, m_udf, m_rv}) begin errs++; $display("FAIL rnd_sticky n=%0d got %b want %b", n, {ovf, udf, rd_valid}, {m_ovf, m_udf, m_rv}); end
      if (m_rv) begin
        vec++; if (dout !== m_dout) begin errs++; $display("FAIL rnd_data n=%0d got %h want %h", n, dout, m_dout); end
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    vec++; if (rd_valid !== 1'b1) begin errs++; $display("FAIL ar_rv1 got %b want 1", rd_valid); end
    #2;
    rst_n = 0;
    #1;
    mreset();
    vec++; if (rd_valid !== 1'b0 || count !== '0) begin errs++; $display("FAIL ar_drop got %b/%0d want 0/0", rd_valid, count); end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
`else
  task automatic test_fwft();
    logic [15:0] exp [$];
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    exp.push_back(last_w);
    vec++; if (rd_valid !== 1'b0) begin errs++; $display("FAIL fw_rv0 got %b want 0", rd_valid); end
    cyc(0, 0, 0);
    vec++; if (rd_valid !== 1'b1 || dout !== exp[0]) begin errs++; $display("FAIL fw_present got %b/%h want 1/%h", rd_valid, dout, exp[0]); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      exp.push_back(last_w);
    end
    vec++; if (count !== 5 || dout !== exp[0]) begin errs++; $display("FAIL fw_hold got %0d/%h want 5/%h", count, dout, exp[0]); end
    for (int i = 1; i < 5; i++) begin
      cyc(0, 1, 0);
      vec++; if (rd_valid !== 1'b1 || dout !== exp[i]) begin errs++; $display("FAIL fw_stream i=%0d got %b/%h want 1/%h", i, rd_valid, dout, exp[i]); end
      vec++; if (count !== fifo_cnt_t'(5 - i)) begin errs++; $display("FAIL fw_count i=%0d got %0d want %0d", i, count, 5 - i); end
    end
    cyc(0, 1, 0);
    vec++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin errs++; $display("FAIL fw_drain got %b/%b want 0/1", rd_valid, empty); end
    cyc(0, 1, 0);
    vec++; if (udf !== 1'b1) begin errs++; $display("FAIL fw_udf got %b want 1", udf); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FIFO_CTRL_FWFT_EN
    test_underflow();
    test_full_ovf();
    test_full_both();
    test_clr();
    test_empty_both();
    test_latency();
    test_interleave();
    test_back_to_back();
    test_async_reset();
`else
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
